// File: rtl/q_stream_tx.sv
// rtl/q_stream_tx.sv - clocked front-end transmitter that serialises words into (pi, si) symbols for a Q-flop self-timed chain
module q_stream_tx #(
  parameter int WIDTH        = 8,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int START_CYCLES = 3,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             start,
  output logic             stage_rst,
  output logic             pi,
  output logic             si,
  output logic             busy
);

  localparam int CNT_MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > START_CYCLES + 1) ? CNT_MAX_A : START_CYCLES + 1;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int BW        = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] START_CNT = CW'(START_CYCLES);
  localparam logic [CW-1:0] START_END = CW'(START_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEND,
    S_SPACE,
    S_END,
    S_TAIL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_next;

  assign cur_bit    = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  // pi/si are registered from the state being left, so every symbol lags its
  // state by one cycle; in_ready/busy follow the state entered, which lets the
  // last spacer cycle overlap the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      start     <= 1'b1;
      stage_rst <= 1'b1;
      pi        <= 1'b0;
      si        <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      pi <= 1'b0;
      si <= 1'b0;
      case (state)
        S_INIT: begin
          // stage_rst outlives start by one cycle so flops clear before gating opens
          if (cnt == START_END) begin
            state     <= S_IDLE;
            cnt       <= '0;
            stage_rst <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt   <= cnt + 1'b1;
            start <= (cnt < START_CNT);
          end
        end
        S_IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            bit_idx  <= '0;
            cnt      <= '0;
            state    <= S_SEND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SEND: begin
          pi <= 1'b1;
          si <= cur_bit;
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= S_SPACE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SPACE: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= S_END;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg_next;
              state   <= S_SEND;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_END: begin
          si <= 1'b1;
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= S_TAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TAIL: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_stream_tx.sv
// tb/tb_q_stream_tx.sv - self-checking bench for q_stream_tx (default and minimum configurations)
module tb_q_stream_tx;

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic [7:0] data;
    logic [5:0] exp;  // {start, stage_rst, in_ready, busy, pi, si}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, start, stage_rst, pi, si, busy;

  logic       m_rst = 1'b1;
  logic [0:0] m_in_data = '0;
  logic       m_in_valid = 1'b0;
  logic       m_in_ready, m_start, m_stage_rst, m_pi, m_si, m_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  q_stream_tx u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .stage_rst(stage_rst),
    .pi(pi), .si(si), .busy(busy)
  );

  q_stream_tx #(
    .WIDTH(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .START_CYCLES(1), .LSB_FIRST(1'b0)
  ) u_min (
    .clk(clk), .rst(m_rst), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .start(m_start), .stage_rst(m_stage_rst),
    .pi(m_pi), .si(m_si), .busy(m_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {start,stage_rst,in_ready,busy,pi,si}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {start, stage_rst, in_ready, busy, pi, si};
  endfunction

  // Expected pi/si at offset t after the acceptance edge for the default configuration
  function automatic logic [1:0] exp_sym(input logic [7:0] w, input int t);
    int u;
    if (t == 0) return 2'b00;
    u = t - 1;
    if (u < 48) return ((u % 6) < 4) ? {1'b1, w[u / 6]} : 2'b00;
    u = u - 48;
    if (u < 4) return 2'b01;
    return 2'b00;
  endfunction

  vec_t init_v[7];
  vec_t min_v[10];

  // abort_at >= 0 raises rst after sampling that offset and returns early
  task automatic send_word(input logic [7:0] w, input bit scramble, input bit hold_valid,
                           input logic [7:0] next_w, input int abort_at, input string name);
    chk({name, "_ready_before"}, outs() & 6'b001000, 6'b001000);
    in_valid = 1'b1;
    in_data  = w;
    step();
    for (int t = 0; t <= 54; t++) begin
      if (t > 0) step();
      chk($sformatf("%s_t%0d", name, t), outs(),
          {2'b00, (t == 54), (t < 54), exp_sym(w, t)});
      if (t == abort_at) begin
        rst = 1'b1;
        return;
      end
      in_valid = hold_valid;
      if (hold_valid && t == 54) in_data = next_w;
      else in_data = scramble ? 8'($urandom) : w;
    end
  endtask

  initial begin
    init_v[0] = '{1'b1, 1'b0, 8'h00, 6'b110100};
    init_v[1] = '{1'b1, 1'b0, 8'h00, 6'b110100};
    init_v[2] = '{1'b0, 1'b1, 8'hA5, 6'b110100};
    init_v[3] = '{1'b0, 1'b1, 8'hA5, 6'b110100};
    init_v[4] = '{1'b0, 1'b1, 8'hA5, 6'b110100};
    init_v[5] = '{1'b0, 1'b1, 8'hA5, 6'b010100};
    init_v[6] = '{1'b0, 1'b1, 8'hA5, 6'b001000};

    min_v[0] = '{1'b1, 1'b0, 8'h00, 6'b110100};
    min_v[1] = '{1'b0, 1'b0, 8'h00, 6'b110100};
    min_v[2] = '{1'b0, 1'b0, 8'h00, 6'b010100};
    min_v[3] = '{1'b0, 1'b0, 8'h00, 6'b001000};
    min_v[4] = '{1'b0, 1'b1, 8'h01, 6'b000100};
    min_v[5] = '{1'b0, 1'b0, 8'h00, 6'b000111};
    min_v[6] = '{1'b0, 1'b0, 8'h00, 6'b000100};
    min_v[7] = '{1'b0, 1'b0, 8'h00, 6'b000101};
    min_v[8] = '{1'b0, 1'b0, 8'h00, 6'b001000};
    min_v[9] = '{1'b0, 1'b0, 8'h00, 6'b001000};

    // Reset, init sequence, with in_valid raised early during INIT
    for (int i = 0; i < 7; i++) begin
      rst      = init_v[i].rst;
      in_valid = init_v[i].in_valid;
      in_data  = init_v[i].data;
      step();
      chk($sformatf("init_row%0d", i), outs(), init_v[i].exp);
    end

    // Early-valid word accepted on the first in_ready edge
    send_word(8'hA5, 1'b0, 1'b0, 8'h00, -1, "a5");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle%0d", i), outs(), 6'b001000);
    end

    // Back-to-back with in_data scrambled in flight
    send_word(8'h00, 1'b1, 1'b1, 8'hFF, -1, "b2b_00");
    send_word(8'hFF, 1'b1, 1'b0, 8'h00, -1, "b2b_ff");

    // Reset during the 4th data symbol of 0x3C
    send_word(8'h3C, 1'b0, 1'b0, 8'h00, 19, "abort");
    in_valid = 1'b0;
    step();
    chk("abort_reset", outs(), 6'b110100);
    for (int i = 2; i < 7; i++) begin
      rst      = init_v[i].rst;
      in_valid = init_v[i].in_valid;
      in_data  = init_v[i].data;
      step();
      chk($sformatf("reinit_row%0d", i), outs(), init_v[i].exp);
    end
    send_word(8'h5A, 1'b0, 1'b0, 8'h00, -1, "after_abort");

    // Minimum configuration
    for (int i = 0; i < 10; i++) begin
      m_rst      = min_v[i].rst;
      m_in_valid = min_v[i].in_valid;
      m_in_data  = min_v[i].data[0];
      step();
      chk($sformatf("min_row%0d", i),
          {m_start, m_stage_rst, m_in_ready, m_busy, m_pi, m_si}, min_v[i].exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_stream_tx.md
Name: q_stream_tx

Overview:
- Clocked transmitter that drives the front end of a Q-flop self-timed pipeline chain.
- Generates the chain's `start`/`rst` initialisation sequence.
- Serialises accepted parallel words into the level-coded (pi, si) symbol stream the first stage samples with its local clock.
- Each symbol is held stable, then return-to-zero spaced, so level-sampling stages never merge consecutive equal bits.
- Sits between the synchronous core and the first q_stage.

Parameters:
- WIDTH, 8: bits per word.
- HOLD_CYCLES, 4: cycles each data or end symbol is held stable (>=1).
- GAP_CYCLES, 2: cycles of spacer (pi=0, si=0) after every symbol (>=1).
- START_CYCLES, 3: cycles `start` is asserted after reset release (>=1).
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to send; sampled only on acceptance.
- in_valid  input  1  word available.
- in_ready  output  1  transmitter can accept; a word is accepted when in_valid and in_ready are both high at a clk edge.
- start  output  1  Q-flop reset pulse for the pipeline chain.
- stage_rst  output  1  input-gating reset for the pipeline chain.
- pi  output  1  data-symbol-active level.
- si  output  1  data bit / end marker level.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered, with no combinational input-to-output paths.
- Reset values while rst=1: state INIT, start=1, stage_rst=1, pi=0, si=0, in_ready=0, busy=1, all counters and the shift register cleared.
- Symbol encoding:
  - Data bit: pi=1, si=bit.
  - End of word: pi=0, si=1.
  - Spacer/idle: pi=0, si=0.
  - pi=1 and si=1 together is legal only as a data "1".
- INIT:
  - start=1 for exactly START_CYCLES cycles after the first edge with rst=0.
  - stage_rst stays 1 for START_CYCLES+1 cycles; it releases one cycle after start, so the flops clear before input gating opens.
  - Then go to IDLE.
- IDLE:
  - Outputs: in_ready=1, busy=0, pi=0, si=0.
  - On acceptance: load in_data into the shift register, clear the bit index, and go to SEND.
  - in_ready=0 from the next cycle.
- SEND:
  - Outputs: pi=1, si=current bit, for HOLD_CYCLES cycles; then go to SPACE.
- SPACE:
  - Outputs: pi=0, si=0 for GAP_CYCLES cycles.
  - If WIDTH bits have been sent: go to END.
  - Otherwise: advance the bit index and go to SEND.
- END:
  - Outputs: pi=0, si=1 for HOLD_CYCLES cycles, then go to TAIL.
- TAIL:
  - Outputs: pi=0, si=0 for GAP_CYCLES cycles, then go to IDLE.
- Timing:
  - Latency: acceptance at edge k puts pi=1 on the outputs after edge k+1.
  - Word period, acceptance edge to in_ready=1: 1 + WIDTH*(HOLD_CYCLES+GAP_CYCLES) + HOLD_CYCLES + GAP_CYCLES - 1 cycles.
  - Back-to-back words are accepted on the first IDLE cycle.
- Input handling:
  - in_valid while in_ready=0 (INIT or any busy state) is ignored; no queuing.
  - in_data changes after acceptance have no effect on the word in flight.
- Reset mid-operation:
  - rst=1 in any state aborts at the next edge and the word in flight is discarded.
  - No END symbol is emitted; outputs go to reset values and INIT reruns in full.
- Counters:
  - Cycle counter is sized for max(HOLD_CYCLES, GAP_CYCLES, START_CYCLES+1).
  - Bit index is sized for WIDTH; it saturates and never wraps within a word.
- WIDTH=1 is legal: one SEND/SPACE pair, then END.

Test Plan:
- Initialisation sequence:
  - Stimulus: rst=1 for 2 cycles, then 0 (default params).
  - Required: start=1 for 3 cycles after release; stage_rst=1 for 4; in_ready=1 in the 5th cycle; pi=si=0 throughout.
- Single word:
  - Stimulus: accept 0xA5 with LSB_FIRST=1.
  - Required: si = 1,0,1,0,0,1,0,1, each with pi=1 for 4 cycles and 2 spacer cycles between symbols.
  - Then END (pi=0, si=1) for 4 cycles, TAIL for 2.
  - in_ready=1 exactly 54 cycles after the acceptance edge.
- Back-to-back words:
  - Stimulus: in_valid held high with 0x00 then 0xFF; in_data toggled during SEND.
  - Required: the second word is accepted on the first IDLE cycle; the transmitted bits match the values captured at acceptance.
- Reset mid-word:
  - Stimulus: rst=1 during the 4th SEND of 0x3C.
  - Required: next cycle pi=0, si=0, start=1, in_ready=0; no END symbol; full INIT repeats; the next word transmits cleanly.
- Early in_valid:
  - Stimulus: in_valid=1 during INIT.
  - Required: no acceptance until in_ready=1, and the word is accepted on that edge.
- Minimum configuration:
  - Stimulus: WIDTH=1, HOLD_CYCLES=1, GAP_CYCLES=1, START_CYCLES=1, LSB_FIRST=0; send 1.
  - Required output sequence: pi/si = 11, 00, 01, 00, then IDLE.
